// File: rtl/arms_regfile_wb.sv
// ARMS write-back stage and register file: one write port, two combinational read ports, R31 = XZR.
// Defining REGFILE_BYPASS_EN forwards same-cycle write data to matching read ports.
module arms_regfile_wb #(
   parameter int DATA_W   = 32,
   parameter int NREG     = 32,
   parameter int ZERO_REG = 31,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREG-1:0]   dselect,
   input  logic [DATA_W-1:0] dbus,
   input  logic [NREG-1:0]   aselect,
   input  logic [NREG-1:0]   bselect,
   output logic [DATA_W-1:0] abus,
   output logic [DATA_W-1:0] bbus,
   output logic              sel_err,
   output logic [CNT_W-1:0]  wr_count
);

   localparam logic [NREG-1:0] ONE = NREG'(1);

   logic [NREG-1:0][DATA_W-1:0] regs;
   logic                        d_known;
   logic                        d_onehot;
   logic                        wr_en;
   logic                        d_err;
   logic                        byp_a;
   logic                        byp_b;

   function automatic logic is_onehot(input logic [NREG-1:0] v);
      return (v != '0) && ((v & (v - ONE)) == '0);
   endfunction

   // Multi-hot or all-zero selects read as 0, as does the zero register.
   function automatic logic [DATA_W-1:0] read_port(input logic [NREG-1:0]             sel,
                                                   input logic [NREG-1:0][DATA_W-1:0] rf);
      logic [DATA_W-1:0] v;
      v = '0;
      if (is_onehot(sel) && !sel[ZERO_REG])
         for (int i = 0; i < NREG; i++)
            if (sel[i]) v = rf[i];
      return v;
   endfunction

   // NOTE: every output of this block is assigned on every pass, so no latch can be inferred.
   always_comb begin
      d_known  = !$isunknown({dselect, dbus});
      d_onehot = d_known && is_onehot(dselect);
      wr_en    = d_onehot && !dselect[ZERO_REG];
      d_err    = !d_known || ((dselect != '0) && !d_onehot);
   end

   // NOTE: the file is built from flops, so reset clears every entry at once; a RAM macro could not.
   // NOTE: non-blocking updates keep the read ports on pre-edge contents during a same-cycle write.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         regs     <= '0;
         sel_err  <= 1'b0;
         wr_count <= '0;
      end else begin
         if (wr_en) begin
            for (int i = 0; i < NREG; i++)
               if (dselect[i]) regs[i] <= dbus;
            wr_count <= wr_count + CNT_W'(1);
         end
         if (d_err) sel_err <= 1'b1;
      end
   end

`ifdef REGFILE_BYPASS_EN
   assign byp_a = wr_en && (aselect == dselect);
   assign byp_b = wr_en && (bselect == dselect);
`else
   assign byp_a = 1'b0;
   assign byp_b = 1'b0;
`endif

   assign abus = byp_a ? dbus : read_port(aselect, regs);
   assign bbus = byp_b ? dbus : read_port(bselect, regs);

endmodule

// File: tb/tb_arms_regfile_wb.sv
// Directed scoreboard bench for arms_regfile_wb; expected values are queued with stimulus, popped on check.
module tb_arms_regfile_wb;

   localparam int DATA_W = 32;
   localparam int NREG   = 32;
   localparam int CNT_W  = 16;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } exp_t;

   exp_t sb[$];
   int   passed = 0;
   int   fails  = 0;
   int   total  = 0;

   logic              clk     = 1'b0;
   logic              reset   = 1'b0;
   logic [NREG-1:0]   dselect = '0;
   logic [DATA_W-1:0] dbus    = '0;
   logic [NREG-1:0]   aselect = '0;
   logic [NREG-1:0]   bselect = '0;
   logic [DATA_W-1:0] abus;
   logic [DATA_W-1:0] bbus;
   logic              sel_err;
   logic [CNT_W-1:0]  wr_count;

   always #5 clk = ~clk;

   arms_regfile_wb dut (
      .clk      (clk),
      .reset    (reset),
      .dselect  (dselect),
      .dbus     (dbus),
      .aselect  (aselect),
      .bselect  (bselect),
      .abus     (abus),
      .bbus     (bbus),
      .sel_err  (sel_err),
      .wr_count (wr_count)
   );

   function automatic logic [NREG-1:0] bit_sel(input int i);
      return NREG'(1) << i;
   endfunction

   task automatic push(input string tag, input logic [31:0] exp);
      exp_t e;
      e.tag = tag;
      e.exp = exp;
      sb.push_back(e);
   endtask

   task automatic check(input logic [31:0] observed);
      exp_t e;
      total++;
      if (sb.size() == 0) begin
         fails++;
         $error("FAIL scoreboard_empty observed=%h", observed);
         return;
      end
      e = sb.pop_front();
      assert (observed === e.exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", e.tag, observed, e.exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic write_reg(input logic [NREG-1:0] sel, input logic [DATA_W-1:0] data);
      dselect = sel;
      dbus    = data;
      tick();
      dselect = '0;
      dbus    = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired before end of sequence");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset then read
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset   = 1'b1;
      aselect = bit_sel(20);
      bselect = bit_sel(0);
      push("reset_abus", 32'h0);
      push("reset_bbus", 32'h0);
      push("reset_sel_err", 32'h0);
      push("reset_wr_count", 32'h0);
      #1;
      check(abus);
      check(bbus);
      check(32'(sel_err));
      check(32'(wr_count));

      // Write and read-back
      write_reg(bit_sel(20), 32'h0000_0AAA);
      aselect = bit_sel(20);
      push("wr_r20_abus", 32'h0000_0AAA);
      push("wr_r20_count", 32'd1);
      #1;
      check(abus);
      check(32'(wr_count));

      write_reg(bit_sel(0), 32'h0000_0002);
      bselect = bit_sel(0);
      push("wr_r0_bbus", 32'h0000_0002);
      push("wr_r0_count", 32'd2);
      #1;
      check(bbus);
      check(32'(wr_count));

      // Zero register
      write_reg(bit_sel(31), 32'h1234_5678);
      aselect = bit_sel(31);
      bselect = bit_sel(31);
      push("xzr_abus", 32'h0);
      push("xzr_bbus", 32'h0);
      push("xzr_count", 32'd2);
      push("xzr_sel_err", 32'h0);
      #1;
      check(abus);
      check(bbus);
      check(32'(wr_count));
      check(32'(sel_err));

      // Illegal multi-hot write select
      write_reg(32'h0030_0000, 32'hFFFF_FFFF);
      aselect = bit_sel(20);
      bselect = bit_sel(21);
      push("multi_r20", 32'h0000_0AAA);
      push("multi_r21", 32'h0);
      push("multi_sel_err", 32'h1);
      push("multi_count", 32'd2);
      #1;
      check(abus);
      check(bbus);
      check(32'(sel_err));
      check(32'(wr_count));

      for (int k = 1; k <= 5; k++) write_reg(bit_sel(k), 32'h100 + k);
      aselect = bit_sel(3);
      bselect = bit_sel(5);
      push("sticky_sel_err", 32'h1);
      push("five_wr_count", 32'd7);
      push("rd_r3", 32'h0000_0103);
      push("rd_r5", 32'h0000_0105);
      #1;
      check(32'(sel_err));
      check(32'(wr_count));
      check(abus);
      check(bbus);

      write_reg('0, 32'hDEAD_BEEF);
      aselect = bit_sel(20);
      bselect = bit_sel(20);
      push("zero_sel_count", 32'd7);
      push("same_reg_a", 32'h0000_0AAA);
      push("same_reg_b", 32'h0000_0AAA);
      #1;
      check(32'(wr_count));
      check(abus);
      check(bbus);

      aselect = bit_sel(20) | bit_sel(0);
      bselect = '0;
      push("multi_read_a", 32'h0);
      push("zero_read_b", 32'h0);
      #1;
      check(abus);
      check(bbus);

      // Same-cycle write and read
      write_reg(bit_sel(22), 32'h0000_0AAA);
      dselect = bit_sel(22);
      dbus    = 32'h0000_0AA0;
      aselect = bit_sel(22);
      bselect = bit_sel(22);
      push("rdw_abus", BYPASS ? 32'h0000_0AA0 : 32'h0000_0AAA);
      push("rdw_bbus", BYPASS ? 32'h0000_0AA0 : 32'h0000_0AAA);
      #1;
      check(abus);
      check(bbus);
      tick();
      dselect = '0;
      dbus    = '0;
      push("rdw_after_abus", 32'h0000_0AA0);
      push("rdw_after_count", 32'd9);
      #1;
      check(abus);
      check(32'(wr_count));

      // Mid-operation asynchronous reset, with a write pending
      write_reg(bit_sel(25), 32'h0000_0AAC);
      aselect = bit_sel(25);
      push("r25_before_reset", 32'h0000_0AAC);
      push("count_before_reset", 32'd10);
      #1;
      check(abus);
      check(32'(wr_count));
      #1;
      dselect = bit_sel(25);
      dbus    = 32'h0000_0005;
      reset   = 1'b0;
      push("async_rst_abus", 32'h0);
      push("async_rst_count", 32'h0);
      push("async_rst_sel_err", 32'h0);
      #1;
      check(abus);
      check(32'(wr_count));
      check(32'(sel_err));
      tick();
      push("rst_wins_abus", 32'h0);
      push("rst_wins_count", 32'h0);
      #1;
      check(abus);
      check(32'(wr_count));
      dselect = '0;
      dbus    = '0;
      reset   = 1'b1;
      push("post_rst_abus", 32'h0);
      #1;
      check(abus);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
